// File: rtl/work_loader.sv
// Job feeder for the double-SHA256 nonce search core: assembles a framed byte stream into a
// validated job and commits it atomically, pulsing the core reset on every commit.
module work_loader #(
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         hash_clk_i,
    input  logic         reset_n_i,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i,
    output logic         rx_ready_o,
    output logic [255:0] midstate_o,
    output logic [95:0]  work_data_o,
    output logic [31:0]  nonce_min_o,
    output logic [31:0]  nonce_max_o,
    output logic         miner_reset_o,
    output logic         job_loaded_o,
    output logic [15:0]  frame_ok_cnt_o,
    output logic         err_checksum_o,
    output logic         err_timeout_o,
    output logic         err_range_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_e;

    state_e         state_q, state_d;
    logic [415:0]   staging_q;
    logic [5:0]     byte_cnt_q;
    logic [7:0]     xor_q;
    logic [TW-1:0]  idle_cnt_q;
    logic           rx_ready_q;
    logic [255:0]   midstate_q;
    logic [95:0]    work_data_q;
    logic [31:0]    nonce_min_q;
    logic [31:0]    nonce_max_q;
    logic           miner_reset_q;
    logic           job_loaded_q;
    logic [15:0]    frame_ok_cnt_q;
    logic           err_checksum_q;
    logic           err_timeout_q;
    logic           err_range_q;

    logic accept;
    logic timeout;
    logic chk_err;
    logic range_err;
    logic commit;
    logic in_frame;

    always_comb begin
        state_d   = state_q;
        accept    = rx_valid_i && rx_ready_q;
        in_frame  = (state_q == PAYLOAD) || (state_q == CHECK);
        timeout   = 1'b0;
        chk_err   = 1'b0;
        range_err = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && rx_data_i == SOF_BYTE) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                if (accept) begin
                    if (byte_cnt_q == 6'd51) state_d = CHECK;
                end else if (idle_cnt_q == IDLE_LIMIT) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                // Checksum has priority over the nonce range test.
                if (accept) begin
                    if (rx_data_i != xor_q) begin
                        chk_err = 1'b1;
                        state_d = IDLE;
                    end else if (staging_q[63:32] > staging_q[31:0]) begin
                        range_err = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = COMMIT;
                    end
                end else if (idle_cnt_q == IDLE_LIMIT) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge hash_clk_i) begin
        if (state_q == PAYLOAD && accept) staging_q <= {staging_q[407:0], rx_data_i};
    end

    always_ff @(posedge hash_clk_i) begin
        if (!reset_n_i) begin
            byte_cnt_q <= '0;
            xor_q      <= '0;
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= (accept || !in_frame) ? '0 : idle_cnt_q + 1'b1;
            if (state_q == IDLE && accept) begin
                byte_cnt_q <= '0;
                xor_q      <= '0;
            end else if (state_q == PAYLOAD && accept) begin
                byte_cnt_q <= byte_cnt_q + 6'd1;
                xor_q      <= xor_q ^ rx_data_i;
            end
        end
    end

    // Job outputs only move on commit; the core samples them continuously.
    always_ff @(posedge hash_clk_i) begin
        if (!reset_n_i) begin
            rx_ready_q     <= 1'b1;
            midstate_q     <= '0;
            work_data_q    <= '0;
            nonce_min_q    <= '0;
            nonce_max_q    <= '0;
            miner_reset_q  <= 1'b1;
            job_loaded_q   <= 1'b0;
            frame_ok_cnt_q <= '0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            rx_ready_q     <= (state_d != COMMIT);
            err_checksum_q <= chk_err;
            err_timeout_q  <= timeout;
            err_range_q    <= range_err;
            miner_reset_q  <= commit || !job_loaded_q;
            if (commit) begin
                midstate_q     <= staging_q[415:160];
                work_data_q    <= staging_q[159:64];
                nonce_min_q    <= staging_q[63:32];
                nonce_max_q    <= staging_q[31:0];
                job_loaded_q   <= 1'b1;
                frame_ok_cnt_q <= frame_ok_cnt_q + 16'd1;
            end
        end
    end

    assign rx_ready_o     = rx_ready_q;
    assign midstate_o     = midstate_q;
    assign work_data_o    = work_data_q;
    assign nonce_min_o    = nonce_min_q;
    assign nonce_max_o    = nonce_max_q;
    assign miner_reset_o  = miner_reset_q;
    assign job_loaded_o   = job_loaded_q;
    assign frame_ok_cnt_o = frame_ok_cnt_q;
    assign err_checksum_o = err_checksum_q;
    assign err_timeout_o  = err_timeout_q;
    assign err_range_o    = err_range_q;

endmodule

// File: tb/tb_work_loader.sv
// Self-checking bench for work_loader: table of frames plus hand sequences for timeout and
// mid-frame reset, with a cycle-accurate scoreboard of expected commit/error events.
module tb_work_loader;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         resetN;
    logic [7:0]   rxData;
    logic         rxValid;
    logic         rxReady;
    logic [255:0] midstate;
    logic [95:0]  workData;
    logic [31:0]  nonceMin;
    logic [31:0]  nonceMax;
    logic         minerReset;
    logic         jobLoaded;
    logic [15:0]  frameOkCnt;
    logic         errChecksum;
    logic         errTimeout;
    logic         errRange;

    always #5 clk = ~clk;

    work_loader #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .hash_clk_i    (clk),
        .reset_n_i     (resetN),
        .rx_data_i     (rxData),
        .rx_valid_i    (rxValid),
        .rx_ready_o    (rxReady),
        .midstate_o    (midstate),
        .work_data_o   (workData),
        .nonce_min_o   (nonceMin),
        .nonce_max_o   (nonceMax),
        .miner_reset_o (minerReset),
        .job_loaded_o  (jobLoaded),
        .frame_ok_cnt_o(frameOkCnt),
        .err_checksum_o(errChecksum),
        .err_timeout_o (errTimeout),
        .err_range_o   (errRange)
    );

    // Event kinds: 0 commit, 1 checksum error, 2 range error, 3 timeout, 7 none
    typedef struct {
        logic [255:0] mid;
        logic [95:0]  work;
        logic [31:0]  nMin;
        logic [31:0]  nMax;
        logic         flipChk;
        int           expKind;
    } frameVec_t;

    typedef struct {
        int           kind;
        int           due;
        logic [415:0] payload;
    } expEvent_t;

    expEvent_t    sbQ[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [415:0] modelJob;
    logic         modelLoaded;
    logic [15:0]  modelCnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [415:0] actual, input logic [415:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: samples just after each falling edge and pops an expectation per DUT event.
    initial begin
        int        kind;
        int        nEv;
        logic      isCommit;
        expEvent_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!resetN) begin
                modelJob    = '0;
                modelLoaded = 1'b0;
                modelCnt    = '0;
                sbQ.delete();
                continue;
            end
            isCommit = (frameOkCnt != modelCnt);
            nEv  = int'(isCommit) + int'(errChecksum) + int'(errRange) + int'(errTimeout);
            kind = 7;
            if (isCommit)    kind = 0;
            if (errChecksum) kind = 1;
            if (errRange)    kind = 2;
            if (errTimeout)  kind = 3;
            if (nEv > 1) checkOutput("single event per cycle", 416'(nEv), 416'(1));
            if (kind != 7) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected event", 416'(kind), 416'(7));
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("event kind", 416'(kind), 416'(e.kind));
                    checkOutput("event cycle", 416'(cyc), 416'(e.due));
                    if (e.kind == 0 && kind == 0) begin
                        modelJob    = e.payload;
                        modelLoaded = 1'b1;
                        modelCnt    = modelCnt + 16'd1;
                        checkOutput("miner_reset commit pulse", 416'(minerReset), 416'(1));
                    end
                end
            end else begin
                if (sbQ.size() > 0 && cyc > sbQ[0].due) begin
                    checkOutput("missing event", 416'(kind), 416'(sbQ[0].kind));
                    void'(sbQ.pop_front());
                end
                checkOutput("miner_reset level", 416'(minerReset), 416'(!modelLoaded));
            end
            checkOutput("job outputs", {midstate, workData, nonceMin, nonceMax}, modelJob);
            checkOutput("frame_ok_cnt", 416'(frameOkCnt), 416'(modelCnt));
            checkOutput("job_loaded", 416'(jobLoaded), 416'(modelLoaded));
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap, output int acceptCyc);
        repeat (gap) @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        for (int g = 0; !rxReady && g < 8; g++) @(negedge clk);
        if (!rxReady) checkOutput("rx_ready wait", 416'(rxReady), 416'(1));
        @(posedge clk);
        @(negedge clk);
        rxValid   = 1'b0;
        acceptCyc = cyc;
    endtask

    task automatic applyStimulus(input frameVec_t v, input int maxGap, input int stallIdx,
                                 input int stallLen, input int abortAt, output int lastCyc);
        logic [415:0] p;
        logic [7:0]   b;
        logic [7:0]   chk;
        int           g;
        p   = {v.mid, v.work, v.nMin, v.nMax};
        chk = 8'h00;
        sendByte(8'hA5, 0, lastCyc);
        for (int i = 0; i < 52; i++) begin
            if (i == abortAt) return;
            b   = p[415 - 8*i -: 8];
            chk = chk ^ b;
            g   = (i == stallIdx) ? stallLen : int'($urandom_range(0, maxGap));
            sendByte(b, g, lastCyc);
        end
        if (v.flipChk) chk[0] = ~chk[0];
        sendByte(chk, 0, lastCyc);
        sbQ.push_back('{kind: v.expKind, due: (v.expKind == 0) ? lastCyc + 1 : lastCyc, payload: p});
        if (v.expKind == 0) checkOutput("rx_ready low in commit", 416'(rxReady), 416'(0));
    endtask

    frameVec_t vecs[6];
    frameVec_t validVec;

    initial begin
        int lastCyc;
        vecs[0] = '{256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1EFF,
                    96'hA5A5_0102_A503_0405_0607, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0};
        vecs[1] = '{256'hDEADBEEF_0BADF00D_12345678_9ABCDEF0_CAFEBABE_55AA55AA_F0E1D2C3_B4A59687,
                    96'h1122_3344_5566_7788_99AA, 32'h0000_1000, 32'h0000_2000, 1'b0, 0};
        vecs[2] = '{256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_F0F0_3C3C_C3C3_AAAA_5555_0000_FFFF,
                    96'h0A0B_0C0D_0E0F_1011_1213, 32'h0000_0100, 32'h0000_0200, 1'b1, 1};
        vecs[3] = '{256'h1, 96'h2, 32'h0000_0010, 32'h0000_000F, 1'b0, 2};
        vecs[4] = '{256'hFEED_FACE, 96'hBEEF, 32'h0000_0005, 32'h0000_0005, 1'b0, 0};
        vecs[5] = '{256'h77, 96'h88, 32'h0000_0020, 32'h0000_001F, 1'b1, 1};
        validVec = '{256'hA5A5A5A5_00000000_11111111_22222222_33333333_44444444_55555555_66666666,
                     96'h9999_8888_7777_6666_5555, 32'h0000_0042, 32'h0000_4242, 1'b0, 0};

        resetN  = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        checkOutput("reset rx_ready", 416'(rxReady), 416'(1));
        checkOutput("reset miner_reset", 416'(minerReset), 416'(1));
        checkOutput("reset job_loaded", 416'(jobLoaded), 416'(0));
        checkOutput("reset outputs", {midstate, workData, nonceMin, nonceMax}, '0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], (i % 2 == 0) ? 0 : 2, -1, 0, -1, lastCyc);
            repeat (3) @(negedge clk);
        end

        $display("[TB] timeout after %0d idle cycles", TMO);
        applyStimulus(validVec, 0, -1, 0, 10, lastCyc);
        sbQ.push_back('{kind: 3, due: lastCyc + TMO, payload: '0});
        repeat (TMO + 2) @(negedge clk);
        applyStimulus(validVec, 0, -1, 0, -1, lastCyc);
        repeat (3) @(negedge clk);

        $display("[TB] stall of %0d idle cycles inside frame", TMO - 1);
        applyStimulus(vecs[1], 0, 10, TMO - 1, -1, lastCyc);
        repeat (3) @(negedge clk);
        applyStimulus(vecs[4], 0, 51, TMO - 1, -1, lastCyc);
        repeat (3) @(negedge clk);

        $display("[TB] garbage, gapped payload, reset mid-frame");
        sendByte(8'h00, 1, lastCyc);
        sendByte(8'hFF, 2, lastCyc);
        applyStimulus(vecs[0], 3, -1, 0, 30, lastCyc);
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        checkOutput("post-reset miner_reset", 416'(minerReset), 416'(1));
        checkOutput("post-reset frame_ok_cnt", 416'(frameOkCnt), 416'(0));
        checkOutput("post-reset outputs", {midstate, workData, nonceMin, nonceMax}, '0);
        sendByte(8'h00, 0, lastCyc);
        applyStimulus(validVec, 1, -1, 0, -1, lastCyc);
        repeat (4) @(negedge clk);
        checkOutput("final frame_ok_cnt", 416'(frameOkCnt), 416'(1));
        checkOutput("scoreboard drained", 416'(sbQ.size()), 416'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
